// File: rtl/demorgan_sweep_ctrl.sv
// Exhaustive De Morgan sweep controller: drives every {a,b} pair into two
// gate implementations, compares both against ~(a&b), counts mismatches.
// Optional macro DEMORGAN_FAIL_CAPTURE_EN adds fail_vec (first failing vector).
module demorgan_sweep_ctrl #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   a_drv,
    output logic [WIDTH-1:0]   b_drv,
    input  logic [WIDTH-1:0]   c_lhs,
    input  logic [WIDTH-1:0]   c_rhs,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_cnt
`ifdef DEMORGAN_FAIL_CAPTURE_EN
   ,output logic [2*WIDTH-1:0] fail_vec
`endif
);

    localparam int VW = 2 * WIDTH;
    localparam logic [3:0] CNT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [VW-1:0] VEC_ONE = {{(VW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETL,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [VW-1:0]   vec_q;
    logic [3:0]      cnt_q;
    logic [7:0]      err_q;
    logic            pass_q;
    logic [WIDTH-1:0] golden;
    logic            mismatch;
    logic            last_vec;
    logic            launch;
    logic            kill;

`ifdef DEMORGAN_FAIL_CAPTURE_EN
    logic [VW-1:0]   fail_q;
`endif

    assign golden   = ~(vec_q[VW-1:WIDTH] & vec_q[WIDTH-1:0]);
    assign mismatch = (c_lhs != golden) || (c_rhs != golden);
    assign last_vec = &vec_q;
    assign launch   = (state_q == S_IDLE) && start;
    assign kill     = (state_q != S_IDLE) && abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (abort)           state_d = S_IDLE;
                else if (SETTLE > 0) state_d = S_SETL;
                else                 state_d = S_CHECK;
            end
            S_SETL: begin
                if (abort)             state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (abort)         state_d = S_IDLE;
                else if (last_vec) state_d = S_DONE;
                else               state_d = S_DRIVE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector, settle counter, error count, verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= 4'd0;
            err_q  <= 8'd0;
            pass_q <= 1'b0;
`ifdef DEMORGAN_FAIL_CAPTURE_EN
            fail_q <= '0;
`endif
        end else if (launch) begin
            vec_q  <= '0;
            err_q  <= 8'd0;
            pass_q <= 1'b0;
`ifdef DEMORGAN_FAIL_CAPTURE_EN
            fail_q <= '0;
`endif
        end else if (kill) begin
            pass_q <= 1'b0;
        end else begin
            if (state_q == S_DRIVE) begin
                cnt_q <= CNT_INIT;
            end
            if (state_q == S_SETL && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == S_CHECK) begin
                if (mismatch && err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
`ifdef DEMORGAN_FAIL_CAPTURE_EN
                if (mismatch && err_q == 8'd0) begin
                    fail_q <= vec_q;
                end
`endif
                if (last_vec) begin
                    pass_q <= !mismatch && (err_q == 8'd0);
                end else begin
                    vec_q <= vec_q + VEC_ONE;
                end
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        pass    = pass_q;
        err_cnt = err_q;
        a_drv   = vec_q[VW-1:WIDTH];
        b_drv   = vec_q[WIDTH-1:0];
`ifdef DEMORGAN_FAIL_CAPTURE_EN
        fail_vec = fail_q;
`endif
    end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: vector table, corner sequences and
// randomized fault patterns against a per-vector reference count.
module tb_demorgan_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A: WIDTH=1, SETTLE=1
    logic       start_a = 1'b0;
    logic       abort_a = 1'b0;
    logic       a_drv_a, b_drv_a, c_lhs_a, c_rhs_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a;
    bit         sl_a = 0, sr_a = 0;
    bit   [3:0] lf_a = 0, rf_a = 0;
`ifdef DEMORGAN_FAIL_CAPTURE_EN
    logic [1:0] fv_a;
`endif

    assign c_lhs_a = sl_a ? 1'b0 : (~(a_drv_a & b_drv_a)) ^ lf_a[{a_drv_a, b_drv_a}];
    assign c_rhs_a = sr_a ? 1'b0 : (~(a_drv_a & b_drv_a)) ^ rf_a[{a_drv_a, b_drv_a}];

    demorgan_sweep_ctrl #(.WIDTH(1), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .a_drv(a_drv_a), .b_drv(b_drv_a), .c_lhs(c_lhs_a), .c_rhs(c_rhs_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a)
`ifdef DEMORGAN_FAIL_CAPTURE_EN
       ,.fail_vec(fv_a)
`endif
    );

    // DUT B: WIDTH=5, SETTLE=0
    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [4:0] a_drv_b, b_drv_b, c_lhs_b, c_rhs_b;
    logic       busy_b, done_b, pass_b;
    logic [7:0] err_b;
    bit         sl_b = 0;
    logic [4:0] lf_b [1024];
    logic [4:0] rf_b [1024];
`ifdef DEMORGAN_FAIL_CAPTURE_EN
    logic [9:0] fv_b;
`endif

    assign c_lhs_b = sl_b ? 5'd0 : (~(a_drv_b & b_drv_b)) ^ lf_b[{a_drv_b, b_drv_b}];
    assign c_rhs_b = (~(a_drv_b & b_drv_b)) ^ rf_b[{a_drv_b, b_drv_b}];

    demorgan_sweep_ctrl #(.WIDTH(5), .SETTLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .a_drv(a_drv_b), .b_drv(b_drv_b), .c_lhs(c_lhs_b), .c_rhs(c_rhs_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
`ifdef DEMORGAN_FAIL_CAPTURE_EN
       ,.fail_vec(fv_b)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Pulse start, wait for done; latency counted from the first DRIVE cycle
    task automatic run_a(output int lat, output logic [7:0] e, output logic p,
                         output logic [1:0] fv, output logic after, output logic [1:0] v6);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        lat = 0; v6 = 2'b00; fv = 2'b00;
        while (!done_a && lat < 100) begin
            @(negedge clk); lat++;
            if (lat == 6) v6 = {a_drv_a, b_drv_a};
        end
        e = err_a; p = pass_a;
`ifdef DEMORGAN_FAIL_CAPTURE_EN
        fv = fv_a;
`endif
        @(negedge clk); after = done_a | busy_a;
    endtask

    task automatic run_b(output int lat, output logic [7:0] e, output logic p, output logic [9:0] fv);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        lat = 0; fv = 10'd0;
        while (!done_b && lat < 3000) begin
            @(negedge clk); lat++;
        end
        e = err_b; p = pass_b;
`ifdef DEMORGAN_FAIL_CAPTURE_EN
        fv = fv_b;
`endif
    endtask

    // Reference: a vector fails when either gate output differs from ~(a&b)
    function automatic int model_a(input bit sl, input bit sr, input bit [3:0] lf,
                                   input bit [3:0] rf, output int fv);
        int cnt = 0;
        fv = 0;
        for (int v = 0; v < 4; v++) begin
            int a = (v >> 1) & 1;
            int b = v & 1;
            int g = (~(a & b)) & 1;
            int l = sl ? 0 : (g ^ int'(lf[v]));
            int r = sr ? 0 : (g ^ int'(rf[v]));
            if (l != g || r != g) begin
                if (cnt == 0) fv = v;
                cnt++;
            end
        end
        return cnt;
    endfunction

    function automatic int model_b(input bit sl, output int fv);
        int cnt = 0;
        fv = 0;
        for (int v = 0; v < 1024; v++) begin
            int a = (v >> 5) & 31;
            int b = v & 31;
            int g = (~(a & b)) & 31;
            int l = sl ? 0 : (g ^ int'(lf_b[v]));
            int r = g ^ int'(rf_b[v]);
            if (l != g || r != g) begin
                if (cnt == 0) fv = v;
                cnt++;
            end
        end
        return cnt;
    endfunction

    typedef struct {
        string  nm;
        bit     sl, sr;
        bit [3:0] lf, rf;
        int     err;
        bit     pass;
        int     fv;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, cyc, nd, mcnt, mfv, dens;
        logic [7:0] e;
        logic p, after;
        logic [1:0] fv, v6;
        logic [9:0] fvb;

        tbl[0] = '{"good",     0, 0, 4'b0000, 4'b0000, 0, 1, 0};
        tbl[1] = '{"rhs_st0",  0, 1, 4'b0000, 4'b0000, 3, 0, 0};
        tbl[2] = '{"lhs_st0",  1, 0, 4'b0000, 4'b0000, 3, 0, 0};
        tbl[3] = '{"last_only",0, 0, 4'b1000, 4'b0000, 1, 0, 3};
        tbl[4] = '{"split",    0, 0, 4'b0010, 4'b0100, 2, 0, 1};
        tbl[5] = '{"both_bad", 0, 0, 4'b0110, 4'b0110, 2, 0, 1};
        for (int v = 0; v < 1024; v++) begin
            lf_b[v] = 5'd0;
            rf_b[v] = 5'd0;
        end

        #1;
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_pass_a", pass_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_drv_a", {a_drv_a, b_drv_a}, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_drv_b", {a_drv_b, b_drv_b}, 0);
        #20; @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sl_a = tbl[i].sl; sr_a = tbl[i].sr;
            lf_a = tbl[i].lf; rf_a = tbl[i].rf;
            run_a(lat, e, p, fv, after, v6);
            check({tbl[i].nm, "_lat"}, lat, 12);
            check({tbl[i].nm, "_err"}, e, tbl[i].err);
            check({tbl[i].nm, "_pass"}, p, tbl[i].pass);
            check({tbl[i].nm, "_vec6"}, v6, 2);
            check({tbl[i].nm, "_pulse"}, after, 0);
`ifdef DEMORGAN_FAIL_CAPTURE_EN
            check({tbl[i].nm, "_fv"}, fv, tbl[i].fv);
`endif
        end

        // Abort in the cycle after the second CHECK
        sl_a = 0; sr_a = 1; lf_a = 0; rf_a = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; cyc = 0;
        while (cyc < 6) begin @(negedge clk); cyc++; end
        check("ab2_err_pre", err_a, 2);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("ab2_busy", busy_a, 0);
        check("ab2_err", err_a, 2);
        check("ab2_pass", pass_a, 0);
        nd = 0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); nd += int'(done_a); end
        check("ab2_nodone", nd, 0);
        sr_a = 0;
        run_a(lat, e, p, fv, after, v6);
        check("ab2_rerun_lat", lat, 12);
        check("ab2_rerun_pass", p, 1);
        check("ab2_rerun_err", e, 0);

        // Abort coinciding with the final CHECK (which would mismatch)
        lf_a = 4'b1000;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; cyc = 0;
        while (cyc < 11) begin @(negedge clk); cyc++; end
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("abl_busy", busy_a, 0);
        check("abl_err", err_a, 0);
        check("abl_pass", pass_a, 0);
        nd = int'(done_a);
        for (int k = 0; k < 3; k++) begin @(negedge clk); nd += int'(done_a); end
        check("abl_nodone", nd, 0);
        lf_a = 0;

        // Asynchronous reset during SETTLE
        sr_a = 1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; cyc = 0;
        while (cyc < 4) begin @(negedge clk); cyc++; end
        check("rst_mid_pre", {err_a, a_drv_a, b_drv_a}, {8'd1, 2'b01});
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_drv", {a_drv_a, b_drv_a}, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_err", err_a, 0);
        check("rst_mid_pass", pass_a, 0);
        @(negedge clk); rst_n = 1'b1;
        sr_a = 0;

        // start held high across a whole sweep
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); cyc = 0; nd = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            nd += int'(done_a);
            if (k == 12) check("hold_done12", done_a, 1);
            if (k == 12) check("hold_pass", pass_a, 1);
            if (k == 13) check("hold_idle", busy_a, 0);
            if (k == 14) check("hold_restart", busy_a, 1);
            if (k == 14) check("hold_vec0", {a_drv_a, b_drv_a}, 0);
        end
        check("hold_one_done", nd, 1);
        start_a = 1'b0; abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("hold_abort", busy_a, 0);

        // Random fault patterns on the 1-bit instance
        for (int t = 0; t < 8; t++) begin
            sl_a = ($urandom_range(0, 3) == 0);
            sr_a = ($urandom_range(0, 3) == 0);
            lf_a = 4'($urandom);
            rf_a = 4'($urandom);
            mcnt = model_a(sl_a, sr_a, lf_a, rf_a, mfv);
            run_a(lat, e, p, fv, after, v6);
            check("rnd_a_lat", lat, 12);
            check("rnd_a_err", e, mcnt);
            check("rnd_a_pass", p, int'(mcnt == 0));
`ifdef DEMORGAN_FAIL_CAPTURE_EN
            check("rnd_a_fv", fv, mcnt == 0 ? 0 : mfv);
`endif
        end
        sl_a = 0; sr_a = 0; lf_a = 0; rf_a = 0;

        // Wide instance: lhs stuck at 0 gives 1023 mismatches
        sl_b = 1;
        mcnt = model_b(sl_b, mfv);
        check("st0_model", mcnt, 1023);
        run_b(lat, e, p, fvb);
        check("st0_lat", lat, 2048);
        check("st0_err", e, 255);
        check("st0_pass", p, 0);
`ifdef DEMORGAN_FAIL_CAPTURE_EN
        check("st0_fv", fvb, 0);
`endif
        sl_b = 0;

        // Wide instance: sparse then dense random faults
        for (int t = 0; t < 2; t++) begin
            dens = (t == 0) ? 1 : 30;
            for (int v = 0; v < 1024; v++) begin
                lf_b[v] = ($urandom_range(0, 99) < dens) ? 5'($urandom_range(1, 31)) : 5'd0;
                rf_b[v] = ($urandom_range(0, 199) < dens) ? 5'($urandom_range(1, 31)) : 5'd0;
            end
            mcnt = model_b(1'b0, mfv);
            run_b(lat, e, p, fvb);
            check("rnd_b_lat", lat, 2048);
            check("rnd_b_err", e, mcnt > 255 ? 255 : mcnt);
            check("rnd_b_pass", p, int'(mcnt == 0));
`ifdef DEMORGAN_FAIL_CAPTURE_EN
            check("rnd_b_fv", fvb, mcnt == 0 ? 0 : mfv);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
